vga_fetch_arbiter: RTL and testbench

Shares the single-port frame-buffer SRAM between the display line fetcher and the pixel writer (drawing engine). It prefetches display lines into a ping-pong line buffer one line ahead of the beam. It asserts hold to the VGA timing controller until the first line of a frame is resident. Display fetch has priority over the writer; the writer is served in idle cycles.

---
 rtl/vga_fetch_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vga_fetch_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_arbiter.sv
// Frame-buffer SRAM arbiter: prefetches display lines into a ping-pong line buffer
// ahead of the beam and serves the pixel writer in idle cycles. Optional: WRITER_SLOT_EN.
module vga_fetch_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 800,
    parameter int NUM_LINES  = 600,
    parameter int LB_AW      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    output logic              hold,
    output logic              disp_bank,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underrun
);

    localparam int LC_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [LB_AW-1:0] LAST_WORD = LB_AW'(LINE_WORDS - 1);
    localparam logic [LB_AW:0]   WORDS     = (LB_AW + 1)'(LINE_WORDS);
    localparam logic [LC_W-1:0]  LAST_LINE = LC_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, READY, FETCH, DONE} state_t;

    state_t            state, state_n;
    logic [LC_W-1:0]   line_cnt;
    logic [LB_AW:0]    rd_word;
    logic [LB_AW-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              lb_we_q;
    logic              fill_bank;

    logic fetching, line_done, more_reads, issue, new_line, grant, toggle;
    logic slot_busy, wr_gap_ok;

    assign fetching   = (state == PREFETCH) || (state == FETCH);
    assign line_done  = fetching && lb_we_q && (lb_addr == LAST_WORD);
    assign more_reads = (rd_word < WORDS) && !slot_busy;
    assign toggle     = line_start && !frame_start && (state != IDLE);
    assign grant      = wr_req && !wr_ack && !issue && wr_gap_ok;

    // The line-buffer write trails each read by one cycle; an abort suppresses it at once.
    assign lb_we    = lb_we_q && !frame_start;
    assign lb_wdata = mem_rdata;
    assign lb_bank  = fetching ? fill_bank : ~disp_bank;

`ifdef WRITER_SLOT_EN
    logic [2:0] slot_cnt;

    assign slot_busy = (slot_cnt == 3'd6);
    assign wr_gap_ok = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slot_cnt <= '0;
        else if (frame_start || new_line)
            slot_cnt <= '0;
        else if (fetching)
            slot_cnt <= slot_cnt + 3'd1;
    end
`else
    assign slot_busy = 1'b0;
    assign wr_gap_ok = !rd_valid;
`endif

    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        new_line = 1'b0;
        if (frame_start) begin
            state_n = PREFETCH;
            issue   = 1'b1;
        end else begin
            case (state)
                PREFETCH: begin
                    if (line_done) begin
                        state_n  = FETCH;
                        issue    = 1'b1;
                        new_line = 1'b1;
                    end else begin
                        issue = more_reads;
                    end
                end
                FETCH: begin
                    if (line_done)
                        state_n = (line_cnt == LAST_LINE) ? DONE : READY;
                    else
                        issue = more_reads;
                end
                READY: begin
                    if (line_start) begin
                        state_n  = FETCH;
                        issue    = 1'b1;
                        new_line = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            line_cnt  <= '0;
            rd_word   <= '0;
            rd_idx    <= '0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            lb_we_q   <= 1'b0;
            lb_addr   <= '0;
            fill_bank <= 1'b0;
            hold      <= 1'b1;
            disp_bank <= 1'b0;
            underrun  <= 1'b0;
            wr_ack    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state    <= state_n;
            rd_valid <= issue;
            wr_ack   <= grant;
            mem_we   <= grant;
            lb_we_q  <= rd_valid && !frame_start;

            if (issue)
                mem_addr <= frame_start ? '0 : rd_addr;
            else if (grant)
                mem_addr <= wr_addr;
            if (grant)
                mem_wdata <= wr_data;

            // A new frame restarts the fetch from address 0 into bank 0.
            if (frame_start) begin
                rd_addr   <= ADDR_W'(1);
                rd_word   <= (LB_AW + 1)'(1);
                rd_idx    <= '0;
                lb_addr   <= '0;
                line_cnt  <= '0;
                fill_bank <= 1'b0;
                disp_bank <= 1'b0;
                underrun  <= 1'b0;
                hold      <= 1'b1;
            end else begin
                if (rd_valid)
                    lb_addr <= rd_idx;
                if (issue) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    rd_word <= new_line ? (LB_AW + 1)'(1) : rd_word + (LB_AW + 1)'(1);
                    rd_idx  <= new_line ? '0 : rd_word[LB_AW-1:0];
                end
                if (new_line) begin
                    line_cnt  <= line_cnt + LC_W'(1);
                    fill_bank <= ~(disp_bank ^ toggle);
                end
                if (toggle)
                    disp_bank <= ~disp_bank;
                if (toggle && fetching)
                    underrun <= 1'b1;
                if (state == PREFETCH && line_done)
                    hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed self-checking bench for vga_fetch_arbiter with a small frame geometry.
module tb_vga_fetch_arbiter;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 16;
    localparam int NUM_LINES  = 6;
    localparam int LB_AW      = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              line_start;
    logic              hold;
    logic              disp_bank;
    logic              lb_we;
    logic              lb_bank;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb_wdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              underrun;

    int assertions = 0;
    int failures   = 0;
    int lb_we_count = 0;

    logic [DATA_W-1:0] sram [256];
    logic              sram_wr [256];
    logic [DATA_W-1:0] lb0 [LINE_WORDS];
    logic [DATA_W-1:0] lb1 [LINE_WORDS];

    vga_fetch_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
        .NUM_LINES(NUM_LINES), .LB_AW(LB_AW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .hold(hold), .disp_bank(disp_bank), .lb_we(lb_we), .lb_bank(lb_bank),
        .lb_addr(lb_addr), .lb_wdata(lb_wdata), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return {8'hA5, a};
    endfunction

    // Synchronous single-port SRAM: unwritten words return a fixed address pattern.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) sram_wr[i] <= 1'b0;
        end else if (mem_we) begin
            sram[mem_addr]    <= mem_wdata;
            sram_wr[mem_addr] <= 1'b1;
        end else begin
            mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr] : pattern(mem_addr);
        end
    end

    always @(posedge clk) begin
        if (lb_we) begin
            if (lb_bank) lb1[lb_addr] <= lb_wdata;
            else         lb0[lb_addr] <= lb_wdata;
            lb_we_count <= lb_we_count + 1;
        end
    end

    function automatic int bank_errors(input logic bank, input int base);
        int errs = 0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if ((bank ? lb1[i] : lb0[i]) !== pattern(8'(base + i))) errs++;
        end
        return errs;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic fs, input logic ls);
        frame_start = fs;
        line_start  = ls;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
    endtask

    initial begin
        int n;
        int last_lb;
        int snap;
        logic ack_seen;

        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_hold",     32'(hold),      32'd1);
        checkOutput("rst_disp",     32'(disp_bank), 32'd0);
        checkOutput("rst_lb_we",    32'(lb_we),     32'd0);
        checkOutput("rst_lb_bank",  32'(lb_bank),   32'd1);
        checkOutput("rst_lb_addr",  32'(lb_addr),   32'd0);
        checkOutput("rst_wr_ack",   32'(wr_ack),    32'd0);
        checkOutput("rst_mem_we",   32'(mem_we),    32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr),  32'd0);
        checkOutput("rst_underrun", 32'(underrun),  32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle_hold", 32'(hold), 32'd1);

        // Prefetch of line 0 into bank 0
        applyStimulus(1'b1, 1'b0);
        checkOutput("pf_first_addr", 32'(mem_addr), 32'd0);
        checkOutput("pf_lb_bank",    32'(lb_bank),  32'd0);
        checkOutput("pf_lb_we_c1",   32'(lb_we),    32'd0);
        tick();
        checkOutput("pf_lb_we_c2",   32'(lb_we),    32'd1);
        checkOutput("pf_lb_addr_c2", 32'(lb_addr),  32'd0);
        checkOutput("pf_addr_c2",    32'(mem_addr), 32'd1);
        n = 1;
        while (hold && n < 200) begin
            n++;
            tick();
        end
`ifndef WRITER_SLOT_EN
        checkOutput("pf_hold_cycles", 32'(n), 32'd17);
`endif
        checkOutput("pf_hold_low",    32'(hold),      32'd0);
        checkOutput("pf_bank0_data",  32'(bank_errors(1'b0, 0)), 32'd0);
        checkOutput("f1_lb_bank",     32'(lb_bank),   32'd1);
        checkOutput("f1_disp",        32'(disp_bank), 32'd0);

        // Writer held during the line-1 fetch
        wr_req = 1'b1; wr_addr = 8'hF0; wr_data = 16'hBEEF;
        n = 0; last_lb = -1;
        while (!wr_ack && n < 100) begin
            if (lb_we) last_lb = n;
            tick();
            n++;
        end
`ifdef WRITER_SLOT_EN
        checkOutput("wr_ack_within_8", 32'(n >= 1 && n <= 8), 32'd1);
`else
        checkOutput("wr_ack_wait",      32'(n),  32'd17);
        checkOutput("wr_ack_after_lb",  32'(n),  32'(last_lb + 1));
`endif
        checkOutput("wr_mem_we",   32'(mem_we),   32'd1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'hF0);
        wr_req = 1'b0;
        tick();
        checkOutput("wr_ack_pulse", 32'(wr_ack), 32'd0);
        checkOutput("wr_sram",      32'(sram[8'hF0]), 32'hBEEF);
        repeat (30) tick();
        checkOutput("f1_bank1_data", 32'(bank_errors(1'b1, 16)), 32'd0);
        checkOutput("f1_underrun",   32'(underrun), 32'd0);

        // line_start in READY: line 2 into bank 0
        applyStimulus(1'b0, 1'b1);
        checkOutput("f2_disp",    32'(disp_bank), 32'd1);
        checkOutput("f2_lb_bank", 32'(lb_bank),   32'd0);
        checkOutput("f2_addr",    32'(mem_addr),  32'd32);
        repeat (24) tick();
        checkOutput("f2_bank0_data", 32'(bank_errors(1'b0, 32)), 32'd0);
        checkOutput("f2_underrun",   32'(underrun), 32'd0);

        // Line 3 with a premature line_start
        applyStimulus(1'b0, 1'b1);
        repeat (4) tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("ur_set",  32'(underrun),  32'd1);
        checkOutput("ur_disp", 32'(disp_bank), 32'd1);
        repeat (24) tick();
        checkOutput("ur_bank1_data", 32'(bank_errors(1'b1, 48)), 32'd0);
        checkOutput("ur_sticky",     32'(underrun), 32'd1);

        // Lines 4 and 5, then abort line 5 with a new frame
        applyStimulus(1'b0, 1'b1);
        repeat (24) tick();
        applyStimulus(1'b0, 1'b1);
        repeat (4) tick();
        checkOutput("ab_lb_we_before", 32'(lb_we), 32'd1);
        frame_start = 1'b1;
        #1;
        checkOutput("ab_lb_we_abort", 32'(lb_we), 32'd0);
        tick();
        frame_start = 1'b0;
        checkOutput("ab_hold",     32'(hold),      32'd1);
        checkOutput("ab_addr",     32'(mem_addr),  32'd0);
        checkOutput("ab_lb_we_c1", 32'(lb_we),     32'd0);
        checkOutput("ab_underrun", 32'(underrun),  32'd0);
        checkOutput("ab_disp",     32'(disp_bank), 32'd0);

        // Complete frame through DONE
        snap = lb_we_count;
        n = 0;
        while (hold && n < 100) begin
            n++;
            tick();
        end
        checkOutput("fr_hold_low", 32'(hold), 32'd0);
        repeat (24) tick();
        for (int k = 2; k < NUM_LINES; k++) begin
            applyStimulus(1'b0, 1'b1);
            repeat (24) tick();
        end
        checkOutput("fr_words",      32'(lb_we_count - snap), 32'd96);
        checkOutput("fr_underrun",   32'(underrun), 32'd0);
        checkOutput("fr_disp",       32'(disp_bank), 32'd0);
        checkOutput("fr_line5_data", 32'(bank_errors(1'b1, 80)), 32'd0);

        snap = lb_we_count;
        applyStimulus(1'b0, 1'b1);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b1);
        repeat (20) tick();
        checkOutput("done_no_reads", 32'(lb_we_count - snap), 32'd0);

        wr_req = 1'b1; wr_addr = 8'h10; wr_data = 16'h1234;
        tick();
        checkOutput("done_wr_ack",  32'(wr_ack),   32'd1);
        checkOutput("done_wr_addr", 32'(mem_addr), 32'h10);
        wr_req = 1'b0;
        tick();
        checkOutput("done_wr_sram", 32'(sram[8'h10]), 32'h1234);

        // Asynchronous reset in the middle of a prefetch with a writer waiting
        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        wr_req = 1'b1; wr_addr = 8'h20; wr_data = 16'h5555;
        reset = 1'b1;
        #1;
        checkOutput("mr_hold",     32'(hold),      32'd1);
        checkOutput("mr_lb_we",    32'(lb_we),     32'd0);
        checkOutput("mr_mem_addr", 32'(mem_addr),  32'd0);
        checkOutput("mr_lb_bank",  32'(lb_bank),   32'd1);
        checkOutput("mr_mem_we",   32'(mem_we),    32'd0);
        ack_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_ack) ack_seen = 1'b1;
        end
        checkOutput("mr_no_ack", 32'(ack_seen), 32'd0);
        wr_req = 1'b0;
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
